// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-bank target.
package i2c_pkg;

    localparam int BYTE_W = 8;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } i2c_state_e;

    // Address byte carries the 7-bit target address in bits [7:1], R/W in bit 0.
    function automatic logic addr_match(input logic [BYTE_W-1:0] addr_byte,
                                        input logic [6:0]        dev_addr);
        return addr_byte[BYTE_W-1:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronises the raw SCL/SDA pin samples and derives the bus events the
// target FSM runs on: SCL edges, START and STOP, all as 1-clk pulses.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Synchroniser chains plus one history flop; reset to the idle (released) bus level
    // so that leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // START/STOP need SCL high on both sides of the SDA transition.
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_peripheral_regfile.sv
// I2C target with a configurable 7-bit address and a NUM_REGS x 8 register bank.
// The master writes a register pointer, then streams data bytes (auto-increment,
// wrapping at NUM_REGS-1); reads after a repeated START stream from the same pointer.
// A local port gives the fabric direct read/write access to the bank.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in the address byte
// ADDR_ACK  | driving ACK for our address; next SCL fall picks PTR or RDATA
// PTR       | shifting in the register pointer byte
// PTR_ACK   | driving ACK for an in-range pointer
// WDATA     | shifting in a data byte for regs[pointer]
// WDATA_ACK | driving ACK for a committed data byte
// RDATA     | shifting out the latched byte, MSB first
// RDATA_ACK | SDA released, sampling the master's ACK/NACK
// IGNORE    | not addressed or NACKed; hands off SDA until START/STOP
module i2c_peripheral_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = $clog2(NUM_REGS),
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_strobe,
    output logic [PTR_W-1:0]  wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    input  logic              loc_we,
    input  logic [PTR_W-1:0]  loc_addr,
    input  logic [BYTE_W-1:0] loc_wdata,
    output logic [BYTE_W-1:0] loc_rdata
);

    localparam logic [3:0]       BIT_CNT_LOAD = 4'(BYTE_W);
    localparam logic [8:0]       NUM_REGS_BYTE = 9'(NUM_REGS);
    localparam logic [PTR_W:0]   NUM_REGS_PTR = (PTR_W + 1)'(NUM_REGS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REGS - 1);

    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;
    logic              sda_s;

    i2c_state_e        state;
    logic [3:0]        bit_cnt;
    logic [BYTE_W-1:0] rx_sh;
    logic [BYTE_W-1:0] tx_sh;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic              rw;
    logic              shift_in;
    logic              byte_in;
    logic              ptr_ok;

    logic [BYTE_W-1:0] regs [NUM_REGS];
    logic [BYTE_W-1:0] ptr_rdata;

    i2c_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    // bit_cnt is a down-counter of bits still to arrive; a byte is complete on the
    // SCL fall that follows the rise which took it to zero, which is also where ACK goes out.
    assign shift_in = scl_rise && (bit_cnt != 4'd0);
    assign byte_in  = scl_fall && (bit_cnt == 4'd0);
    assign ptr_ok   = {1'b0, rx_sh} < NUM_REGS_BYTE;
    assign ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;

    assign ptr_rdata = regs[ptr];
    assign loc_rdata = ({1'b0, loc_addr} < NUM_REGS_PTR) ? regs[loc_addr] : '0;

    // Protocol FSM: START/STOP override everything, otherwise act on synced SCL edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= BIT_CNT_LOAD;
            rx_sh     <= '0;
            tx_sh     <= '0;
            ptr       <= '0;
            rw        <= I2C_RW_WRITE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= BIT_CNT_LOAD;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end

                    ADDR: begin
                        if (shift_in) begin
                            rx_sh   <= {rx_sh[BYTE_W-2:0], sda_s};
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (byte_in) begin
                            bit_cnt <= BIT_CNT_LOAD;
                            if (addr_match(rx_sh, DEV_ADDR)) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= rx_sh[0];
                                state  <= ADDR_ACK;
                            end else begin
                                state  <= IGNORE;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            case (rw)
                                I2C_RW_READ: begin
                                    tx_sh   <= ptr_rdata;
                                    sda_oe  <= ~ptr_rdata[BYTE_W-1];
                                    bit_cnt <= BIT_CNT_LOAD - 1'b1;
                                    state   <= RDATA;
                                end
                                I2C_RW_WRITE: begin
                                    sda_oe  <= 1'b0;
                                    bit_cnt <= BIT_CNT_LOAD;
                                    state   <= PTR;
                                end
                            endcase
                        end
                    end

                    PTR: begin
                        if (shift_in) begin
                            rx_sh   <= {rx_sh[BYTE_W-2:0], sda_s};
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (byte_in) begin
                            bit_cnt <= BIT_CNT_LOAD;
                            if (ptr_ok) begin
                                ptr    <= rx_sh[PTR_W-1:0];
                                sda_oe <= 1'b1;
                                state  <= PTR_ACK;
                            end else begin
                                // Leaving SDA released during the 9th clock is the NACK.
                                state  <= IGNORE;
                            end
                        end
                    end

                    PTR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= BIT_CNT_LOAD;
                            state   <= WDATA;
                        end
                    end

                    WDATA: begin
                        if (shift_in) begin
                            rx_sh   <= {rx_sh[BYTE_W-2:0], sda_s};
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (byte_in) begin
                            bit_cnt   <= BIT_CNT_LOAD;
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= rx_sh;
                            ptr       <= ptr_next;
                            sda_oe    <= 1'b1;
                            state     <= WDATA_ACK;
                        end
                    end

                    WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= BIT_CNT_LOAD;
                            state   <= WDATA;
                        end
                    end

                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt != 4'd0) begin
                                tx_sh   <= {tx_sh[BYTE_W-2:0], 1'b0};
                                sda_oe  <= ~tx_sh[BYTE_W-2];
                                bit_cnt <= bit_cnt - 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                state   <= RDATA_ACK;
                            end
                        end
                    end

                    RDATA_ACK: begin
                        // Only reachable SCL fall here follows an ACKed rise, so the
                        // pointer has already moved on to the next byte.
                        if (scl_rise) begin
                            if (sda_s == I2C_ACK) begin
                                ptr   <= ptr_next;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall) begin
                            tx_sh   <= ptr_rdata;
                            sda_oe  <= ~ptr_rdata[BYTE_W-1];
                            bit_cnt <= BIT_CNT_LOAD - 1'b1;
                            state   <= RDATA;
                        end
                    end

                    IGNORE: begin
                        sda_oe <= 1'b0;
                    end

                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register bank: I2C commit (visible as wr_strobe) wins over a same-cycle local
    // write to the same register; writes to different registers both land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_strobe && (wr_addr == PTR_W'(i))) begin
                    regs[i] <= wr_data;
                end else if (loc_we && (loc_addr == PTR_W'(i))) begin
                    regs[i] <= loc_wdata;
                end
            end
        end
    end

endmodule
